intra_buf_arb: RTL and testbench

Single-port access arbiter placed in front of one intra reference-pixel buffer (row, col or frame SRAM) in the rec_intra path. It merges the reconstruction write-back stream and the prediction reference-read stream onto the buffer's single address/sel port. It buffers writes in a 2-entry FIFO, gives reads priority, and enforces read-after-write ordering and bounded write starvation. One instance is built per buffer (row, col, fra).

---
 rtl/intra_buf_arb_if.sv | 48 ++++
 rtl/intra_buf_arb.sv | 107 ++++++++++
 tb/tb_intra_buf_arb.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/intra_buf_arb_if.sv
// intra_buf_arb_if: bundles the write-back stream, the reference-read stream and the
// single-port buffer connection of one intra_buf_arb instance.
//   write stream : wr_req_i, wr_sel_i, wr_adr_i, wr_dat_i -> wr_rdy_o
//   read stream  : rd_req_i, rd_sel_i, rd_adr_i -> rd_gnt_o, rd_val_o, rd_dat_o
//   status       : busy_o (write FIFO non-empty)
//   buffer port  : mem_sel_o, mem_wr_ena_o, mem_wr_adr_o, mem_wr_dat_o,
//                  mem_rd_ena_o, mem_rd_adr_o <- mem_rd_dat_i
// slave is the arbiter side, master is the requester/buffer environment side.
interface intra_buf_arb_if #(
  parameter int unsigned ADR_W = 8,
  parameter int unsigned DAT_W = 32
) ();
  logic             wr_req_i;
  logic [1:0]       wr_sel_i;
  logic [ADR_W-1:0] wr_adr_i;
  logic [DAT_W-1:0] wr_dat_i;
  logic             wr_rdy_o;
  logic             rd_req_i;
  logic [1:0]       rd_sel_i;
  logic [ADR_W-1:0] rd_adr_i;
  logic             rd_gnt_o;
  logic             rd_val_o;
  logic [DAT_W-1:0] rd_dat_o;
  logic             busy_o;
  logic [1:0]       mem_sel_o;
  logic             mem_wr_ena_o;
  logic [ADR_W-1:0] mem_wr_adr_o;
  logic [DAT_W-1:0] mem_wr_dat_o;
  logic             mem_rd_ena_o;
  logic [ADR_W-1:0] mem_rd_adr_o;
  logic [DAT_W-1:0] mem_rd_dat_i;

  modport slave (
    input  wr_req_i, wr_sel_i, wr_adr_i, wr_dat_i,
    input  rd_req_i, rd_sel_i, rd_adr_i,
    input  mem_rd_dat_i,
    output wr_rdy_o, rd_gnt_o, rd_val_o, rd_dat_o, busy_o,
    output mem_sel_o, mem_wr_ena_o, mem_wr_adr_o, mem_wr_dat_o, mem_rd_ena_o, mem_rd_adr_o
  );

  modport master (
    output wr_req_i, wr_sel_i, wr_adr_i, wr_dat_i,
    output rd_req_i, rd_sel_i, rd_adr_i,
    output mem_rd_dat_i,
    input  wr_rdy_o, rd_gnt_o, rd_val_o, rd_dat_o, busy_o,
    input  mem_sel_o, mem_wr_ena_o, mem_wr_adr_o, mem_wr_dat_o, mem_rd_ena_o, mem_rd_adr_o
  );
endinterface

// File: rtl/intra_buf_arb.sv
// intra_buf_arb: single-port access arbiter in front of one intra reference-pixel buffer.
// Write-backs are queued in a 2-entry FIFO and drained when the read stream leaves a gap,
// when a pending read hits a queued address (read-after-write), or when the queued write
// has lost STARVE_MAX consecutive grants to reads. Exactly one buffer access per cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : intra_buf_arb_if.slave (write stream, read stream, busy, buffer port)
module intra_buf_arb #(
  parameter int unsigned ADR_W      = 8,
  parameter int unsigned DAT_W      = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  intra_buf_arb_if.slave bus
);

  typedef struct packed {
    logic [1:0]       sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } entry_t;

  // Entry 0 is always the FIFO head; a pop shifts entry 1 down.
  entry_t     ent_q [2];
  entry_t     ent_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       rd_val_q;

  logic wr_rdy, busy, push, pop, wr_slot;
  logic hit0, hit1, hazard, starved, issue_wr, issue_rd;

  assign wr_rdy = (cnt_q != 2'd2);
  assign busy   = (cnt_q != 2'd0);
  assign push   = bus.wr_req_i & wr_rdy;
  assign pop    = issue_wr;

  // Hazard compares only entries already queued; an entry pushed this cycle is not visible.
  always_comb begin
    hit0     = (cnt_q != 2'd0) && ({ent_q[0].sel, ent_q[0].adr} == {bus.rd_sel_i, bus.rd_adr_i});
    hit1     = (cnt_q == 2'd2) && ({ent_q[1].sel, ent_q[1].adr} == {bus.rd_sel_i, bus.rd_adr_i});
    hazard   = bus.rd_req_i & (hit0 | hit1);
    starved  = busy & (starve_q == 4'(STARVE_MAX));
    issue_wr = ~rst & (hazard | starved | (~bus.rd_req_i & busy));
    issue_rd = ~rst & bus.rd_req_i & ~(hazard | starved);
  end

  always_comb begin
    bus.mem_sel_o    = 2'd0;
    bus.mem_wr_ena_o = 1'b0;
    bus.mem_wr_adr_o = '0;
    bus.mem_wr_dat_o = '0;
    bus.mem_rd_ena_o = 1'b0;
    bus.mem_rd_adr_o = '0;
    if (issue_wr) begin
      bus.mem_sel_o    = ent_q[0].sel;
      bus.mem_wr_ena_o = 1'b1;
      bus.mem_wr_adr_o = ent_q[0].adr;
      bus.mem_wr_dat_o = ent_q[0].dat;
    end else if (issue_rd) begin
      bus.mem_sel_o    = bus.rd_sel_i;
      bus.mem_rd_ena_o = 1'b1;
      bus.mem_rd_adr_o = bus.rd_adr_i;
    end
  end

  assign bus.wr_rdy_o = wr_rdy;
  assign bus.busy_o   = busy;
  assign bus.rd_gnt_o = issue_rd;
  assign bus.rd_val_o = rd_val_q;
  assign bus.rd_dat_o = bus.mem_rd_dat_i;

  always_comb begin
    ent_d = ent_q;
    // Push lands after the surviving entries: slot 1 only when one entry stays queued.
    wr_slot = (cnt_q == 2'd1) && !pop;
    if (pop) begin
      ent_d[0] = ent_q[1];
    end
    if (push) begin
      ent_d[wr_slot] = {bus.wr_sel_i, bus.wr_adr_i, bus.wr_dat_i};
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    starve_d = starve_q;
    if (!busy || issue_wr) begin
      starve_d = 4'd0;
    end else if (issue_rd && (starve_q != 4'(STARVE_MAX))) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      starve_q <= 4'd0;
      rd_val_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      rd_val_q <= issue_rd;
      ent_q    <= ent_d;
    end
  end

endmodule

// File: tb/tb_intra_buf_arb.sv
module tb_intra_buf_arb;
  localparam int unsigned ADR_W      = 8;
  localparam int unsigned DAT_W      = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam logic [1:0]  TYPE_Y     = 2'd0;
  localparam logic [1:0]  TYPE_U     = 2'd1;
  localparam logic [1:0]  TYPE_V     = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  intra_buf_arb_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

  intra_buf_arb #(
    .ADR_W     (ADR_W),
    .DAT_W     (DAT_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] rd_q [$];
  logic [41:0] wr_q [$];
  logic [31:0] mem    [4][256];
  logic [31:0] shadow [4][256];
  logic        preload;
  logic        prev_gnt;

  function automatic logic [31:0] init_word(input logic [1:0] s, input logic [7:0] a);
    return {8'h5A, 6'd0, s, 8'h00, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Buffer model: 1-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int s = 0; s < 4; s++)
        for (int a = 0; a < 256; a++) mem[s][a] <= init_word(2'(s), 8'(a));
    end else if (bus.mem_wr_ena_o === 1'b1) begin
      mem[bus.mem_sel_o][bus.mem_wr_adr_o] <= bus.mem_wr_dat_o;
    end
    if (bus.mem_rd_ena_o === 1'b1) bus.mem_rd_dat_i <= mem[bus.mem_sel_o][bus.mem_rd_adr_o];
  end

  // Scoreboard monitor: pops an expectation whenever the DUT presents read data or a write.
  always @(negedge clk) begin
    if (bus.rd_val_o === 1'b1) begin
      if (rd_q.size() == 0) check("rd_val_with_empty_queue", 64'(bus.rd_val_o), 64'd0);
      else check("rd_dat", 64'(bus.rd_dat_o), 64'(rd_q.pop_front()));
    end
    if (bus.mem_wr_ena_o === 1'b1) begin
      if (wr_q.size() == 0) check("wr_with_empty_queue", 64'(bus.mem_wr_ena_o), 64'd0);
      else check("wr_entry", 64'({bus.mem_sel_o, bus.mem_wr_adr_o, bus.mem_wr_dat_o}),
                 64'(wr_q.pop_front()));
    end
  end

  // Checks one cycle's handshake outputs at the negedge, then moves to just after the next edge.
  task automatic step(input string tag, input logic e_gnt, input logic e_wr, input logic e_rdy,
                      input logic e_busy);
    @(negedge clk);
    check({tag, ".rd_gnt"}, 64'(bus.rd_gnt_o), 64'(e_gnt));
    check({tag, ".rd_ena"}, 64'(bus.mem_rd_ena_o), 64'(e_gnt));
    check({tag, ".wr_ena"}, 64'(bus.mem_wr_ena_o), 64'(e_wr));
    check({tag, ".wr_rdy"}, 64'(bus.wr_rdy_o), 64'(e_rdy));
    check({tag, ".busy"}, 64'(bus.busy_o), 64'(e_busy));
    check({tag, ".rd_val"}, 64'(bus.rd_val_o), 64'(prev_gnt));
    prev_gnt = e_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [1:0] s, input logic [7:0] a, input logic [31:0] d);
    wr_q.push_back({s, a, d});
    shadow[s][a] = d;
  endtask

  logic [9:0] t_gnt, t_wr, t_rdy, t_busy;
  logic [31:0] wdat [3];
  int rd_idx;

  initial begin
    preload          = 1'b1;
    prev_gnt         = 1'b0;
    bus.wr_req_i     = 1'b0;
    bus.wr_sel_i     = 2'd0;
    bus.wr_adr_i     = '0;
    bus.wr_dat_i     = '0;
    bus.rd_req_i     = 1'b1;
    bus.rd_sel_i     = TYPE_Y;
    bus.rd_adr_i     = 8'h10;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 256; a++) shadow[s][a] = init_word(2'(s), 8'(a));

    // Reset: grants and enables held low even with a read pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.rd_gnt", 64'(bus.rd_gnt_o), 64'd0);
      check("rst.wr_ena", 64'(bus.mem_wr_ena_o), 64'd0);
      check("rst.rd_ena", 64'(bus.mem_rd_ena_o), 64'd0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    preload      = 1'b0;
    bus.rd_req_i = 1'b0;
    @(negedge clk);
    check("idle.mem_sel", 64'(bus.mem_sel_o), 64'd0);
    check("idle.wr_adr", 64'(bus.mem_wr_adr_o), 64'd0);
    check("idle.rd_adr", 64'(bus.mem_rd_adr_o), 64'd0);
    @(posedge clk);
    #1;
    step("idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Read only: one grant per cycle, data one cycle later.
    for (int i = 0; i < 5; i++) begin
      bus.rd_req_i = 1'b1;
      bus.rd_sel_i = TYPE_Y;
      bus.rd_adr_i = 8'(8'h10 + i);
      rd_q.push_back(shadow[TYPE_Y][8'h10 + i]);
      step("rd_only", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    bus.rd_req_i = 1'b0;
    step("rd_tail", 1'b0, 1'b0, 1'b1, 1'b0);

    // Write then read-back of the same address: write drains first.
    bus.wr_req_i = 1'b1;
    bus.wr_sel_i = TYPE_U;
    bus.wr_adr_i = 8'h05;
    bus.wr_dat_i = 32'hA1B2C3D4;
    push_wr(TYPE_U, 8'h05, 32'hA1B2C3D4);
    step("raw_push", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.wr_req_i = 1'b0;
    bus.rd_req_i = 1'b1;
    bus.rd_sel_i = TYPE_U;
    bus.rd_adr_i = 8'h05;
    rd_q.push_back(shadow[TYPE_U][8'h05]);
    step("raw_hazard", 1'b0, 1'b1, 1'b1, 1'b1);
    step("raw_read", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.rd_req_i = 1'b0;
    step("raw_done", 1'b0, 1'b0, 1'b1, 1'b0);

    // Starvation: 4 read grants, then the pending write wins one cycle.
    bus.wr_req_i = 1'b1;
    bus.wr_sel_i = TYPE_V;
    bus.wr_adr_i = 8'h30;
    bus.wr_dat_i = 32'h11112222;
    push_wr(TYPE_V, 8'h30, 32'h11112222);
    step("stv_push", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.wr_req_i = 1'b0;
    rd_idx = 0;
    for (int k = 1; k <= 7; k++) begin
      bus.rd_req_i = 1'b1;
      bus.rd_sel_i = TYPE_Y;
      bus.rd_adr_i = 8'(8'h40 + rd_idx);
      if (k != 5) rd_q.push_back(shadow[TYPE_Y][8'h40 + rd_idx]);
      step("starve", (k != 5), (k == 5), 1'b1, (k <= 5));
      if (k != 5) rd_idx++;
    end
    bus.rd_req_i = 1'b0;
    step("stv_tail", 1'b0, 1'b0, 1'b1, 1'b0);

    // FIFO full under a continuous read stream; third write waits for a drain.
    t_gnt   = 10'b0001011111;
    t_wr    = 10'b0110100000;
    t_rdy   = 10'b1101000011;
    t_busy  = 10'b0111111110;
    wdat[0] = 32'hD0D0D0D0;
    wdat[1] = 32'hD1D1D1D1;
    wdat[2] = 32'hD2D2D2D2;
    rd_idx  = 0;
    for (int c = 0; c < 10; c++) begin
      bus.rd_req_i = (c <= 6);
      bus.rd_sel_i = TYPE_Y;
      bus.rd_adr_i = 8'(8'h50 + rd_idx);
      bus.wr_req_i = (c <= 6);
      bus.wr_sel_i = TYPE_U;
      bus.wr_adr_i = 8'(8'h60 + ((c < 2) ? c : 2));
      bus.wr_dat_i = wdat[(c < 2) ? c : 2];
      if (c <= 2) push_wr(TYPE_U, 8'(8'h60 + c), wdat[c]);
      if (t_gnt[c]) rd_q.push_back(shadow[TYPE_Y][8'h50 + rd_idx]);
      step("full", t_gnt[c], t_wr[c], t_rdy[c], t_busy[c]);
      if (t_gnt[c]) rd_idx++;
    end
    bus.rd_req_i = 1'b0;
    bus.wr_req_i = 1'b0;
    for (int c = 0; c < 3; c++) check("full.mem", 64'(mem[TYPE_U][8'h60 + c]), 64'(wdat[c]));

    // Reset mid-drain: two queued writes are discarded.
    bus.wr_req_i = 1'b1;
    bus.wr_sel_i = TYPE_V;
    bus.wr_adr_i = 8'h70;
    bus.wr_dat_i = 32'hDEAD0070;
    bus.rd_req_i = 1'b1;
    bus.rd_sel_i = TYPE_Y;
    bus.rd_adr_i = 8'h58;
    rd_q.push_back(shadow[TYPE_Y][8'h58]);
    step("mid_q0", 1'b1, 1'b0, 1'b1, 1'b0);
    bus.wr_adr_i = 8'h71;
    bus.wr_dat_i = 32'hDEAD0071;
    bus.rd_adr_i = 8'h59;
    rd_q.push_back(shadow[TYPE_Y][8'h59]);
    step("mid_q1", 1'b1, 1'b0, 1'b1, 1'b1);
    bus.wr_req_i = 1'b0;
    bus.rd_adr_i = 8'h5A;
    rst          = 1'b1;
    step("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    rst          = 1'b0;
    bus.rd_req_i = 1'b0;
    step("mid_after", 1'b0, 1'b0, 1'b1, 1'b0);
    step("mid_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    check("mid.mem70", 64'(mem[TYPE_V][8'h70]), 64'(shadow[TYPE_V][8'h70]));
    check("mid.mem71", 64'(mem[TYPE_V][8'h71]), 64'(shadow[TYPE_V][8'h71]));

    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
